ahb3lite_mem_slave: RTL and testbench
=====================================

AHB3LITE_MEM_SLAVE -- requirements
Module: ahb3lite_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, HADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, HWDATA/HRDATA width.
REQ-003 SHALL have parameter MEM_DEPTH, default 16, number of DATA_WIDTH words stored.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-005 SHALL have parameter WAIT_CYCLES, default 1, range 0..7, wait states per OKAY transfer (used only with AHB_SLAVE_WAIT_EN).
REQ-006 SHALL have port HCLK  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port HRESETn  input  1  reset, synchronous, active-low.
REQ-008 SHALL have ports HSEL input 1 slave select; HADDR input ADDR_WIDTH address; HTRANS input 2 transfer type; HWRITE input 1 direction; HSIZE input 3 size; HBURST input 3 burst type (accepted, ignored).
REQ-009 SHALL have ports HWDATA input DATA_WIDTH write data; HREADY input 1 bus-level ready.
REQ-010 SHALL have ports HREADYOUT output 1 slave ready; HRDATA output DATA_WIDTH read data; HRESP output 1 response.

Function
REQ-011 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; SHALL register HADDR, HWRITE, HSIZE on that edge.
REQ-012 SHALL respond to IDLE/BUSY, or HSEL=0 with HREADY=1, with zero-wait OKAY (HREADYOUT=1, HRESP=OKAY).
REQ-013 SHALL implement states ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2.
REQ-014 SHALL flag an accepted transfer as error if word index (HADDR-BASE_ADDR)>>2 >= MEM_DEPTH, HADDR<BASE_ADDR, HADDR[1:0]!=0, or HSIZE!=WORD.
REQ-015 SHALL on error go ST_ERR1 (HREADYOUT=0, HRESP=ERROR) then ST_ERR2 (HREADYOUT=1, HRESP=ERROR), no memory write, HRDATA=0.
REQ-016 SHALL on non-error go ST_WAIT when wait count >0, else ST_DATA; ST_WAIT drives HREADYOUT=0, HRESP=OKAY, counter decrements each cycle to ST_DATA.
REQ-017 SHALL in ST_DATA drive HREADYOUT=1, HRESP=OKAY; write: store HWDATA at registered index on that edge; read: HRDATA = mem[index] combinationally in that cycle.
REQ-018 SHALL accept the next address phase in the ST_DATA/ST_ERR2 cycle (pipelined); back-to-back transfers with zero wait sustain one transfer per cycle.
REQ-019 SHALL return, for a read immediately following a write to the same word, the newly written value.
REQ-020 SHALL hold HRDATA at 0 outside ST_DATA read cycles.
REQ-021 SHALL ignore HSEL/HTRANS changes while HREADYOUT=0 (address held by master).

Reset
REQ-022 SHALL on HRESETn=0 at a clock edge go ST_IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, wait counter 0, all memory words 0.
REQ-023 SHALL abandon any in-flight transfer on reset with no memory write.

Configuration
REQ-024 SHALL, with AHB_SLAVE_WAIT_EN defined, insert WAIT_CYCLES wait states per OKAY transfer (REQ-016).
REQ-025 SHALL, without AHB_SLAVE_WAIT_EN, omit the wait counter and ST_WAIT entry, always zero-wait; WAIT_CYCLES ignored.

Structure
REQ-026 SHALL use shared package ahb3lite_pkg for HTRANS_state, HRESP_state (OKAY=1'b1, ERROR=1'b0), WRITE/READ, WORD; SHALL add slave state enum slave_state there.
REQ-027 SHALL place storage in sub-module ahb3lite_mem_array (sync write, async read, sync clear).

Verification
REQ-028 Reset then single NONSEQ write 0xDEADBEEF @BASE+0x8, read @0x8 -> HRDATA=0xDEADBEEF, HRESP=OKAY.
REQ-029 Write @BASE+0x40 (index 16, MEM_DEPTH=16) -> ST_ERR1 HREADYOUT=0/ERROR, ST_ERR2 HREADYOUT=1/ERROR, memory unchanged.
REQ-030 Read @BASE+0x2 or HSIZE=3'b001 -> two-cycle ERROR, HRDATA=0.
REQ-031 AHB_SLAVE_WAIT_EN, WAIT_CYCLES=3: write -> exactly 3 cycles HREADYOUT=0 then 1 ready cycle; undefined: 0 wait cycles.
REQ-032 Zero-wait INCR4 writes 1,2,3,4 @0x0..0xC, then reads -> 4 completions in 4 consecutive cycles, data 1..4.
REQ-033 Assert HRESETn=0 during ST_WAIT of a write -> HREADYOUT=1, HRESP=OKAY next cycle, target word reads 0.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite bus encodings and memory-slave FSM states
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic {
        ERROR = 1'b0,
        OKAY  = 1'b1
    } HRESP_state;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } HWRITE_state;

    typedef enum logic [2:0] {
        BYTE     = 3'b000,
        HALFWORD = 3'b001,
        WORD     = 3'b010
    } HSIZE_state;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state;

endpackage

// File: rtl/ahb3lite_mem_array.sv
// rtl/ahb3lite_mem_array.sv - word storage with synchronous write, asynchronous read, synchronous clear
module ahb3lite_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Clear every word on reset (wins over any pending write), otherwise store on we
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// rtl/ahb3lite_mem_slave.sv - AHB3-Lite word memory slave; AHB_SLAVE_WAIT_EN enables WAIT_CYCLES wait states
module ahb3lite_mem_slave
    import ahb3lite_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          MEM_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    slave_state            state;
    slave_state            state_nxt;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] offset_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  ready_state;
    logic                  accept;
    logic                  addr_err;
    logic                  wait_start;
    logic                  wait_last;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_bits;

    // New address phases are only taken in states that drive HREADYOUT high
    assign ready_state = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept      = HSEL && HREADY && ready_state &&
                         ((HTRANS == NONSEQ) || (HTRANS == SEQ));

    assign offset   = HADDR - BASE;
    assign addr_err = (HADDR < BASE) || (HADDR[1:0] != 2'b00) || (HSIZE != WORD) ||
                      ((offset >> 2) >= ADDR_WIDTH'(MEM_DEPTH));

    assign offset_q    = haddr_q - BASE;
    assign idx_q       = offset_q[IDX_W+1:2];
    assign unused_bits = &{1'b0, HBURST, hsize_q, offset_q};

    // Capture the address-phase controls of each accepted transfer
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
        end else if (accept) begin
            haddr_q  <= HADDR;
            hwrite_q <= HWRITE;
            hsize_q  <= HSIZE;
        end
    end

`ifdef AHB_SLAVE_WAIT_EN
    logic [2:0] wait_cnt;

    assign wait_start = (WAIT_CYCLES != 0);
    assign wait_last  = (wait_cnt <= 3'd1);

    // Load the wait-state budget on accept and count it down while in ST_WAIT
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= 3'(WAIT_CYCLES);
        end else if ((state == ST_WAIT) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;

    assign wait_start = 1'b0;
    assign wait_last  = 1'b1;
`endif

    // State register; reset abandons any in-flight transfer
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: errors take two cycles, OKAY transfers optionally pass through ST_WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = ST_ERR1;
                    end else if (wait_start) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_last) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus response and memory strobe per state; read data is zero except in a read data cycle
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = OKAY;
        HRDATA    = '0;
        mem_we    = 1'b0;
        case (state)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_DATA: begin
                if (hwrite_q) begin
                    mem_we = 1'b1;
                end else begin
                    HRDATA = mem_rdata;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = ERROR;
            end
            ST_ERR2: HRESP = ERROR;
            default: ;
        endcase
    end

    ahb3lite_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk    (HCLK),
        .resetn (HRESETn),
        .we     (mem_we),
        .idx    (idx_q),
        .wdata  (HWDATA),
        .rdata  (mem_rdata)
    );

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// tb/tb_ahb3lite_mem_slave.sv - directed self-checking bench for ahb3lite_mem_slave
module tb_ahb3lite_mem_slave;
    import ahb3lite_pkg::*;

`ifdef AHB_SLAVE_WAIT_EN
    localparam int EXP_WAIT = 3;
`else
    localparam int EXP_WAIT = 0;
`endif

    localparam int BB_N = 10;
    localparam logic [31:0] BB_ADDR  [BB_N] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h10};
    localparam logic        BB_WR    [BB_N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] BB_WDATA [BB_N] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'h55, 32'd0};
    localparam logic [31:0] BB_EXP   [BB_N] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'h55};

    logic        clk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign hready = hreadyout;

    ahb3lite_mem_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (16),
        .BASE_ADDR   (32'h0),
        .WAIT_CYCLES (3)
    ) dut (
        .HCLK      (clk),
        .HRESETn   (hresetn),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HBURST    (hburst),
        .HWDATA    (hwdata),
        .HREADY    (hready),
        .HREADYOUT (hreadyout),
        .HRDATA    (hrdata),
        .HRESP     (hresp)
    );

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output int waits, output logic resp_first,
                        output logic resp_last, output logic [31:0] rdata);
        hsel   = 1'b1;
        haddr  = addr;
        htrans = NONSEQ;
        hwrite = wr;
        hsize  = size;
        hburst = 3'b000;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = IDLE;
        haddr  = 32'h0;
        hwdata = wdata;
        resp_first = hresp;
        waits = 0;
        while (!hreadyout && waits < 20) begin
            waits++;
            @(posedge clk); #1;
        end
        resp_last = hresp;
        rdata     = hrdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hreadyout !== 1'b1) begin failures++; $display("FAIL reset_hreadyout: got %0b expected 1", hreadyout); end
        checks++; if (hresp !== OKAY) begin failures++; $display("FAIL reset_hresp: got %0b expected 1", hresp); end
        checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
        hresetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_rw();
        int w; logic rf, rl; logic [31:0] rd;
        xfer(32'h8, 1'b1, WORD, 32'hDEADBEEF, w, rf, rl, rd);
        checks++; if (w !== EXP_WAIT) begin failures++; $display("FAIL single_wr_waits: got %0d expected %0d", w, EXP_WAIT); end
        checks++; if (rl !== OKAY) begin failures++; $display("FAIL single_wr_resp: got %0b expected 1", rl); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL single_wr_hrdata: got %h expected 0", rd); end
        xfer(32'h8, 1'b0, WORD, 32'h0, w, rf, rl, rd);
        checks++; if (w !== EXP_WAIT) begin failures++; $display("FAIL single_rd_waits: got %0d expected %0d", w, EXP_WAIT); end
        checks++; if (rl !== OKAY) begin failures++; $display("FAIL single_rd_resp: got %0b expected 1", rl); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_out_of_range();
        int w; logic rf, rl; logic [31:0] rd;
        xfer(32'h40, 1'b1, WORD, 32'h12345678, w, rf, rl, rd);
        checks++; if (w !== 1) begin failures++; $display("FAIL oor_wait: got %0d expected 1", w); end
        checks++; if (rf !== ERROR) begin failures++; $display("FAIL oor_err1_resp: got %0b expected 0", rf); end
        checks++; if (rl !== ERROR) begin failures++; $display("FAIL oor_err2_resp: got %0b expected 0", rl); end
        xfer(32'h0, 1'b0, WORD, 32'h0, w, rf, rl, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_mem_unchanged: got %h expected 0", rd); end
        checks++; if (rl !== OKAY) begin failures++; $display("FAIL oor_followup_resp: got %0b expected 1", rl); end
    endtask

    task automatic test_misaligned();
        int w; logic rf, rl; logic [31:0] rd;
        xfer(32'h2, 1'b0, WORD, 32'h0, w, rf, rl, rd);
        checks++; if (w !== 1) begin failures++; $display("FAIL unaligned_wait: got %0d expected 1", w); end
        checks++; if (rf !== ERROR) begin failures++; $display("FAIL unaligned_err1: got %0b expected 0", rf); end
        checks++; if (rl !== ERROR) begin failures++; $display("FAIL unaligned_err2: got %0b expected 0", rl); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL unaligned_hrdata: got %h expected 0", rd); end
        xfer(32'h8, 1'b0, HALFWORD, 32'h0, w, rf, rl, rd);
        checks++; if (w !== 1) begin failures++; $display("FAIL halfword_wait: got %0d expected 1", w); end
        checks++; if (rl !== ERROR) begin failures++; $display("FAIL halfword_err2: got %0b expected 0", rl); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL halfword_hrdata: got %h expected 0", rd); end
    endtask

    task automatic test_back_to_back();
        int          a_i = 0;
        int          d_i = -1;
        int          n = 0;
        int          cyc = 0;
        int          comp_cyc [BB_N];
        logic [31:0] comp_dat [BB_N];
        logic        comp_rsp [BB_N];
        logic        rdy;
        hsel   = 1'b1;
        haddr  = BB_ADDR[0];
        htrans = NONSEQ;
        hwrite = BB_WR[0];
        hsize  = WORD;
        hburst = 3'b011;
        while (cyc < 200) begin
            rdy = hreadyout;
            if (rdy && d_i >= 0 && n < BB_N) begin
                comp_cyc[n] = cyc;
                comp_dat[n] = hrdata;
                comp_rsp[n] = hresp;
                n++;
            end
            @(posedge clk); #1;
            if (rdy) begin
                d_i = (a_i < BB_N) ? a_i : -1;
                if (d_i >= 0) hwdata = BB_WDATA[d_i];
                a_i++;
                if (a_i < BB_N) begin
                    hsel   = 1'b1;
                    haddr  = BB_ADDR[a_i];
                    htrans = (a_i == 4 || a_i == 8) ? NONSEQ : SEQ;
                    hwrite = BB_WR[a_i];
                    hsize  = WORD;
                    hburst = (a_i < 8) ? 3'b011 : 3'b001;
                end else begin
                    hsel   = 1'b0;
                    htrans = IDLE;
                end
            end
            if (d_i < 0 && a_i >= BB_N) break;
            cyc++;
        end
        checks++; if (n !== BB_N) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", n, BB_N); end
        for (int i = 0; i < n; i++) begin
            checks++; if (comp_dat[i] !== BB_EXP[i]) begin failures++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, comp_dat[i], BB_EXP[i]); end
            checks++; if (comp_rsp[i] !== OKAY) begin failures++; $display("FAIL b2b_resp[%0d]: got %0b expected 1", i, comp_rsp[i]); end
            if (i > 0) begin
                checks++; if (comp_cyc[i] - comp_cyc[i-1] !== EXP_WAIT + 1) begin
                    failures++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, comp_cyc[i] - comp_cyc[i-1], EXP_WAIT + 1);
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int w; logic rf, rl; logic [31:0] rd;
        logic exp_rdy;
        exp_rdy = (EXP_WAIT > 0) ? 1'b0 : 1'b1;
        hsel   = 1'b1;
        haddr  = 32'h20;
        htrans = NONSEQ;
        hwrite = 1'b1;
        hsize  = WORD;
        hburst = 3'b000;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = IDLE;
        hwdata = 32'h77;
        checks++; if (hreadyout !== exp_rdy) begin failures++; $display("FAIL rstwait_inflight: got %0b expected %0b", hreadyout, exp_rdy); end
        hresetn = 1'b0;
        @(posedge clk); #1;
        checks++; if (hreadyout !== 1'b1) begin failures++; $display("FAIL rstwait_hreadyout: got %0b expected 1", hreadyout); end
        checks++; if (hresp !== OKAY) begin failures++; $display("FAIL rstwait_hresp: got %0b expected 1", hresp); end
        hresetn = 1'b1;
        @(posedge clk); #1;
        xfer(32'h20, 1'b0, WORD, 32'h0, w, rf, rl, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstwait_target: got %h expected 0", rd); end
        xfer(32'h10, 1'b0, WORD, 32'h0, w, rf, rl, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstwait_cleared: got %h expected 0", rd); end
    endtask

    initial begin
        hresetn = 1'b0;
        hsel    = 1'b0;
        haddr   = 32'h0;
        htrans  = IDLE;
        hwrite  = 1'b0;
        hsize   = WORD;
        hburst  = 3'b000;
        hwdata  = 32'h0;
        test_reset();
        test_single_rw();
        test_out_of_range();
        test_misaligned();
        test_back_to_back();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
